// File: rtl/axi_slave_port_pkg.sv
// Bus types and decode helpers shared by the AXI-Lite slave port, its channel
// interfaces and the WAIT-state timeout counter.
package axi_slave_port_pkg;

  localparam int unsigned AXI_ADDR_W = 32;
  localparam int unsigned AXI_DATA_W = 32;
  localparam int unsigned AXI_STRB_W = AXI_DATA_W / 8;

  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    SLVERR = 2'b10
  } axi_response_t;

  typedef enum logic [1:0] {
    IDLE,
    REQUEST,
    WAIT,
    RESPONSE
  } axi_slave_state_t;

  // One extra bit so an address below the base shows up as a negative offset.
  function automatic logic [AXI_ADDR_W:0] window_offset(
    input logic [AXI_ADDR_W-1:0] addr,
    input logic [AXI_ADDR_W-1:0] base
  );
    return {1'b0, addr} - {1'b0, base};
  endfunction

  function automatic logic in_window(
    input logic [AXI_ADDR_W:0] offset,
    input logic [AXI_ADDR_W:0] size
  );
    return !offset[AXI_ADDR_W] && (offset < size);
  endfunction

endpackage

// File: rtl/axi_slave_port_if.sv
// AXI-Lite write (AW/W/B) and read (AR/R) channel bundles with master and
// slave views.
interface axi_write_interface;
  import axi_slave_port_pkg::*;

  logic [AXI_ADDR_W-1:0] AWADDR;
  logic                  AWVALID;
  logic                  AWREADY;
  logic [AXI_DATA_W-1:0] WDATA;
  logic [AXI_STRB_W-1:0] WSTRB;
  logic                  WVALID;
  logic                  WREADY;
  axi_response_t         BRESP;
  logic                  BVALID;
  logic                  BREADY;

  modport slave (
    input  AWADDR, AWVALID, WDATA, WSTRB, WVALID, BREADY,
    output AWREADY, WREADY, BRESP, BVALID
  );

  modport master (
    output AWADDR, AWVALID, WDATA, WSTRB, WVALID, BREADY,
    input  AWREADY, WREADY, BRESP, BVALID
  );
endinterface

interface axi_read_interface;
  import axi_slave_port_pkg::*;

  logic [AXI_ADDR_W-1:0] ARADDR;
  logic                  ARVALID;
  logic                  ARREADY;
  logic [AXI_DATA_W-1:0] RDATA;
  axi_response_t         RRESP;
  logic                  RVALID;
  logic                  RREADY;

  modport slave (
    input  ARADDR, ARVALID, RREADY,
    output ARREADY, RDATA, RRESP, RVALID
  );

  modport master (
    output ARADDR, ARVALID, RREADY,
    input  ARREADY, RDATA, RRESP, RVALID
  );
endinterface

// File: rtl/axi_slave_port_timeout.sv
// WAIT-state watchdog for one slave path; only built with AXI_SLAVE_TIMEOUT_EN.
// expired_o is high in the WAIT cycle where the count reaches TIMEOUT_CYCLES-1.
`ifdef AXI_SLAVE_TIMEOUT_EN
module axi_slave_timeout #(
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic clk,
  input  logic rst,
  input  logic clear_i,
  input  logic enable_i,
  output logic expired_o
);

  localparam int unsigned CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (enable_i && (count_q != LAST)) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expired_o = enable_i && (count_q == LAST);

endmodule
`endif

// File: rtl/axi_slave_port.sv
// AXI-Lite slave endpoint: one address window, independent write/read FSMs,
// single-beat request/done peripheral port. Optional WAIT timeout: AXI_SLAVE_TIMEOUT_EN.
module axi_slave_port
  import axi_slave_port_pkg::*;
#(
  parameter logic [31:0] ADDR_BASE      = 32'h0000_0000,
  parameter int unsigned ADDR_SIZE      = 4096,
  parameter int unsigned TIMEOUT_CYCLES = 256,
  localparam int unsigned AW            = $clog2(ADDR_SIZE)
) (
  input  logic                    axi_ACLK,
  input  logic                    axi_ARESET,
  axi_write_interface.slave       write_channel,
  axi_read_interface.slave        read_channel,
  output logic [AW-1:0]           write_address_o,
  output logic [31:0]             write_data_o,
  output logic [3:0]              write_strobe_o,
  output logic                    write_request_o,
  input  logic                    write_done_i,
  input  logic                    write_error_i,
  output logic [AW-1:0]           read_address_o,
  output logic                    read_request_o,
  input  logic [31:0]             read_data_i,
  input  logic                    read_done_i,
  input  logic                    read_error_i
);

  // READY stays low through reset and rises the cycle after release.
  logic ready_en_q;

  axi_slave_state_t w_state_q, w_state_d;
  logic             aw_held_q, aw_held_d, w_held_q, w_held_d, aw_hit_q, aw_hit_d;
  logic [AW-1:0]    waddr_q, waddr_d;
  logic [31:0]      wdata_q, wdata_d;
  logic [3:0]       wstrb_q, wstrb_d;
  axi_response_t    bresp_q, bresp_d;
  logic             aw_ready, w_ready, w_timeout;

  axi_slave_state_t r_state_q, r_state_d;
  logic [AW-1:0]    raddr_q, raddr_d;
  logic [31:0]      rdata_q, rdata_d;
  axi_response_t    rresp_q, rresp_d;
  logic             ar_ready, r_timeout;

  logic [32:0] aw_offset, ar_offset;
  logic        aw_in_window, ar_in_window;

  assign aw_offset    = window_offset(write_channel.AWADDR, ADDR_BASE);
  assign ar_offset    = window_offset(read_channel.ARADDR, ADDR_BASE);
  assign aw_in_window = in_window(aw_offset, 33'(ADDR_SIZE));
  assign ar_in_window = in_window(ar_offset, 33'(ADDR_SIZE));

  always_comb begin
    w_state_d = w_state_q;
    aw_held_d = aw_held_q;
    w_held_d  = w_held_q;
    aw_hit_d  = aw_hit_q;
    waddr_d   = waddr_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    bresp_d   = bresp_q;
    aw_ready  = 1'b0;
    w_ready   = 1'b0;
    case (w_state_q)
      IDLE: begin
        aw_ready = ready_en_q && !aw_held_q;
        w_ready  = ready_en_q && !w_held_q;
        if (write_channel.AWVALID && aw_ready) begin
          aw_held_d = 1'b1;
          aw_hit_d  = aw_in_window;
          waddr_d   = aw_offset[AW-1:0];
        end
        if (write_channel.WVALID && w_ready) begin
          w_held_d = 1'b1;
          wdata_d  = write_channel.WDATA;
          wstrb_d  = write_channel.WSTRB;
        end
        // Leave IDLE on the edge that completes the pair, not one later.
        if (aw_held_d && w_held_d) begin
          if (aw_hit_d) begin
            w_state_d = REQUEST;
          end else begin
            w_state_d = RESPONSE;
            bresp_d   = SLVERR;
          end
        end
      end
      REQUEST, WAIT: begin
        if (write_done_i) begin
          w_state_d = RESPONSE;
          bresp_d   = write_error_i ? SLVERR : OKAY;
        end else if (w_timeout) begin
          w_state_d = RESPONSE;
          bresp_d   = SLVERR;
        end else begin
          w_state_d = WAIT;
        end
      end
      RESPONSE: begin
        if (write_channel.BREADY) begin
          w_state_d = IDLE;
          aw_held_d = 1'b0;
          w_held_d  = 1'b0;
        end
      end
      default: w_state_d = IDLE;
    endcase
  end

  always_comb begin
    r_state_d = r_state_q;
    raddr_d   = raddr_q;
    rdata_d   = rdata_q;
    rresp_d   = rresp_q;
    ar_ready  = 1'b0;
    case (r_state_q)
      IDLE: begin
        ar_ready = ready_en_q;
        if (read_channel.ARVALID && ar_ready) begin
          raddr_d = ar_offset[AW-1:0];
          if (ar_in_window) begin
            r_state_d = REQUEST;
          end else begin
            r_state_d = RESPONSE;
            rdata_d   = '0;
            rresp_d   = SLVERR;
          end
        end
      end
      REQUEST, WAIT: begin
        if (read_done_i) begin
          r_state_d = RESPONSE;
          rdata_d   = read_data_i;
          rresp_d   = read_error_i ? SLVERR : OKAY;
        end else if (r_timeout) begin
          r_state_d = RESPONSE;
          rdata_d   = '0;
          rresp_d   = SLVERR;
        end else begin
          r_state_d = WAIT;
        end
      end
      RESPONSE: begin
        if (read_channel.RREADY) begin
          r_state_d = IDLE;
        end
      end
      default: r_state_d = IDLE;
    endcase
  end

  always_ff @(posedge axi_ACLK) begin
    if (axi_ARESET) begin
      ready_en_q <= 1'b0;
      w_state_q  <= IDLE;
      aw_held_q  <= 1'b0;
      w_held_q   <= 1'b0;
      aw_hit_q   <= 1'b0;
      waddr_q    <= '0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      bresp_q    <= OKAY;
      r_state_q  <= IDLE;
      raddr_q    <= '0;
      rdata_q    <= '0;
      rresp_q    <= OKAY;
    end else begin
      ready_en_q <= 1'b1;
      w_state_q  <= w_state_d;
      aw_held_q  <= aw_held_d;
      w_held_q   <= w_held_d;
      aw_hit_q   <= aw_hit_d;
      waddr_q    <= waddr_d;
      wdata_q    <= wdata_d;
      wstrb_q    <= wstrb_d;
      bresp_q    <= bresp_d;
      r_state_q  <= r_state_d;
      raddr_q    <= raddr_d;
      rdata_q    <= rdata_d;
      rresp_q    <= rresp_d;
    end
  end

`ifdef AXI_SLAVE_TIMEOUT_EN
  axi_slave_timeout #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_w_timeout (
    .clk       (axi_ACLK),
    .rst       (axi_ARESET),
    .clear_i   (w_state_q == REQUEST),
    .enable_i  (w_state_q == WAIT),
    .expired_o (w_timeout)
  );

  axi_slave_timeout #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_r_timeout (
    .clk       (axi_ACLK),
    .rst       (axi_ARESET),
    .clear_i   (r_state_q == REQUEST),
    .enable_i  (r_state_q == WAIT),
    .expired_o (r_timeout)
  );
`else
  logic unused_timeout_cycles;
  assign unused_timeout_cycles = ^TIMEOUT_CYCLES;
  assign w_timeout = 1'b0;
  assign r_timeout = 1'b0;
`endif

  assign write_channel.AWREADY = aw_ready;
  assign write_channel.WREADY  = w_ready;
  assign write_channel.BVALID  = (w_state_q == RESPONSE);
  assign write_channel.BRESP   = bresp_q;
  assign read_channel.ARREADY  = ar_ready;
  assign read_channel.RVALID   = (r_state_q == RESPONSE);
  assign read_channel.RRESP    = rresp_q;
  assign read_channel.RDATA    = rdata_q;

  assign write_address_o = waddr_q;
  assign write_data_o    = wdata_q;
  assign write_strobe_o  = wstrb_q;
  assign write_request_o = (w_state_q == REQUEST);
  assign read_address_o  = raddr_q;
  assign read_request_o  = (r_state_q == REQUEST);

endmodule

// File: tb/tb_axi_slave_port.sv
// Directed bench for axi_slave_port: vector tables for single transactions plus
// hand-written sequences for ordering, back-pressure, reset and timeout.
module tb_axi_slave_port;
  import axi_slave_port_pkg::*;

  localparam logic [31:0] BASE = 32'h0000_0000;
  localparam int unsigned SIZE = 4096;
`ifdef AXI_SLAVE_TIMEOUT_EN
  localparam int unsigned TO = 4;
`else
  localparam int unsigned TO = 256;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  axi_write_interface wr_if ();
  axi_read_interface  rd_if ();

  logic [11:0] write_address_o, read_address_o;
  logic [31:0] write_data_o, read_data_i;
  logic [3:0]  write_strobe_o;
  logic        write_request_o, write_done_i, write_error_i;
  logic        read_request_o, read_done_i, read_error_i;

  axi_slave_port #(
    .ADDR_BASE      (BASE),
    .ADDR_SIZE      (SIZE),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .axi_ACLK        (clk),
    .axi_ARESET      (rst),
    .write_channel   (wr_if),
    .read_channel    (rd_if),
    .write_address_o (write_address_o),
    .write_data_o    (write_data_o),
    .write_strobe_o  (write_strobe_o),
    .write_request_o (write_request_o),
    .write_done_i    (write_done_i),
    .write_error_i   (write_error_i),
    .read_address_o  (read_address_o),
    .read_request_o  (read_request_o),
    .read_data_i     (read_data_i),
    .read_done_i     (read_done_i),
    .read_error_i    (read_error_i)
  );

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
    int          delay;
    logic        err;
    logic        hit;
    logic [1:0]  resp;
    logic [11:0] off;
  } wvec_t;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] pdata;
    int          delay;
    logic        err;
    logic        hit;
    logic [1:0]  resp;
    logic [31:0] rdata;
    logic [11:0] off;
  } rvec_t;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_write(input wvec_t v, input int idx);
    wr_if.AWADDR  = v.addr;
    wr_if.AWVALID = 1'b1;
    wr_if.WDATA   = v.data;
    wr_if.WSTRB   = v.strb;
    wr_if.WVALID  = 1'b1;
    chk($sformatf("w%0d awready", idx), 32'(wr_if.AWREADY), 1);
    chk($sformatf("w%0d wready", idx), 32'(wr_if.WREADY), 1);
    tick();
    wr_if.AWVALID = 1'b0;
    wr_if.WVALID  = 1'b0;
    chk($sformatf("w%0d request", idx), 32'(write_request_o), 32'(v.hit));
    if (v.hit) begin
      chk($sformatf("w%0d address", idx), 32'(write_address_o), 32'(v.off));
      chk($sformatf("w%0d data", idx), write_data_o, v.data);
      chk($sformatf("w%0d strobe", idx), 32'(write_strobe_o), 32'(v.strb));
      for (int i = 0; i < v.delay; i++) begin
        tick();
        chk($sformatf("w%0d wait request", idx), 32'(write_request_o), 0);
        chk($sformatf("w%0d wait bvalid", idx), 32'(wr_if.BVALID), 0);
      end
      write_done_i  = 1'b1;
      write_error_i = v.err;
      tick();
      write_done_i  = 1'b0;
      write_error_i = 1'b0;
    end
    chk($sformatf("w%0d bvalid", idx), 32'(wr_if.BVALID), 1);
    chk($sformatf("w%0d bresp", idx), 32'(wr_if.BRESP), 32'(v.resp));
    chk($sformatf("w%0d request low", idx), 32'(write_request_o), 0);
    wr_if.BREADY = 1'b1;
    tick();
    wr_if.BREADY = 1'b0;
    chk($sformatf("w%0d bvalid clear", idx), 32'(wr_if.BVALID), 0);
    chk($sformatf("w%0d awready again", idx), 32'(wr_if.AWREADY), 1);
  endtask

  task automatic run_read(input rvec_t v, input int idx);
    rd_if.ARADDR  = v.addr;
    rd_if.ARVALID = 1'b1;
    read_data_i   = v.pdata;
    chk($sformatf("r%0d arready", idx), 32'(rd_if.ARREADY), 1);
    tick();
    rd_if.ARVALID = 1'b0;
    chk($sformatf("r%0d request", idx), 32'(read_request_o), 32'(v.hit));
    chk($sformatf("r%0d arready busy", idx), 32'(rd_if.ARREADY), 0);
    if (v.hit) begin
      chk($sformatf("r%0d address", idx), 32'(read_address_o), 32'(v.off));
      for (int i = 0; i < v.delay; i++) begin
        tick();
        chk($sformatf("r%0d wait rvalid", idx), 32'(rd_if.RVALID), 0);
      end
      read_done_i  = 1'b1;
      read_error_i = v.err;
      tick();
      read_done_i  = 1'b0;
      read_error_i = 1'b0;
      read_data_i  = 32'hFFFF_FFFF;
    end
    chk($sformatf("r%0d rvalid", idx), 32'(rd_if.RVALID), 1);
    chk($sformatf("r%0d rresp", idx), 32'(rd_if.RRESP), 32'(v.resp));
    chk($sformatf("r%0d rdata", idx), rd_if.RDATA, v.rdata);
    rd_if.RREADY = 1'b1;
    tick();
    rd_if.RREADY = 1'b0;
    chk($sformatf("r%0d rvalid clear", idx), 32'(rd_if.RVALID), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    wvec_t wv[5];
    rvec_t rv[5];
    int    pulses;

    wv[0] = '{32'h0000_0008, 32'hDEAD_BEEF, 4'hF, 0, 1'b0, 1'b1, 2'b00, 12'h008};
    wv[1] = '{32'h0000_0FFC, 32'h0123_4567, 4'h0, 2, 1'b1, 1'b1, 2'b10, 12'hFFC};
    wv[2] = '{32'h0000_1000, 32'h1111_2222, 4'hF, 0, 1'b0, 1'b0, 2'b10, 12'h000};
    wv[3] = '{32'h8000_0004, 32'h3333_4444, 4'h1, 0, 1'b0, 1'b0, 2'b10, 12'h000};
    wv[4] = '{32'h0000_0000, 32'hA5A5_A5A5, 4'h3, 1, 1'b0, 1'b1, 2'b00, 12'h000};

    rv[0] = '{32'h0000_0010, 32'hCAFE_F00D, 0, 1'b0, 1'b1, 2'b00, 32'hCAFE_F00D, 12'h010};
    rv[1] = '{32'h0000_1000, 32'hFFFF_FFFF, 0, 1'b0, 1'b0, 2'b10, 32'h0000_0000, 12'h000};
    rv[2] = '{32'h0000_0FFF, 32'h0000_55AA, 3, 1'b1, 1'b1, 2'b10, 32'h0000_55AA, 12'hFFF};
    rv[3] = '{32'hFFFF_FFFC, 32'h0000_0001, 0, 1'b0, 1'b0, 2'b10, 32'h0000_0000, 12'h000};
    rv[4] = '{32'h0000_0804, 32'h8765_4321, 1, 1'b0, 1'b1, 2'b00, 32'h8765_4321, 12'h804};

    wr_if.AWADDR  = '0;
    wr_if.AWVALID = 1'b0;
    wr_if.WDATA   = '0;
    wr_if.WSTRB   = '0;
    wr_if.WVALID  = 1'b0;
    wr_if.BREADY  = 1'b0;
    rd_if.ARADDR  = '0;
    rd_if.ARVALID = 1'b0;
    rd_if.RREADY  = 1'b0;
    write_done_i  = 1'b0;
    write_error_i = 1'b0;
    read_data_i   = '0;
    read_done_i   = 1'b0;
    read_error_i  = 1'b0;

    // Reset values
    tick(); tick(); tick();
    chk("rst awready", 32'(wr_if.AWREADY), 0);
    chk("rst wready", 32'(wr_if.WREADY), 0);
    chk("rst arready", 32'(rd_if.ARREADY), 0);
    chk("rst bvalid", 32'(wr_if.BVALID), 0);
    chk("rst rvalid", 32'(rd_if.RVALID), 0);
    chk("rst rdata", rd_if.RDATA, 0);
    chk("rst bresp", 32'(wr_if.BRESP), 0);
    rst = 1'b0;
    tick();
    chk("post-rst awready", 32'(wr_if.AWREADY), 1);
    chk("post-rst arready", 32'(rd_if.ARREADY), 1);

    for (int i = 0; i < 5; i++) run_write(wv[i], i);
    for (int i = 0; i < 5; i++) run_read(rv[i], i);

    // W three cycles ahead of AW; B held off to show READY back-pressure
    wr_if.WDATA  = 32'h0BAD_F00D;
    wr_if.WSTRB  = 4'hC;
    wr_if.WVALID = 1'b1;
    tick();
    wr_if.WVALID = 1'b0;
    chk("wfirst wready drop", 32'(wr_if.WREADY), 0);
    chk("wfirst awready", 32'(wr_if.AWREADY), 1);
    tick();
    chk("wfirst no req 1", 32'(write_request_o), 0);
    tick();
    chk("wfirst no req 2", 32'(write_request_o), 0);
    wr_if.AWADDR  = 32'h0000_0040;
    wr_if.AWVALID = 1'b1;
    tick();
    wr_if.AWVALID = 1'b0;
    pulses = 0;
    for (int i = 0; i < 6; i++) begin
      if (write_request_o) pulses++;
      write_done_i = write_request_o;
      tick();
    end
    write_done_i = 1'b0;
    chk("wfirst pulses", pulses, 1);
    chk("wfirst address", 32'(write_address_o), 32'h40);
    chk("wfirst data", write_data_o, 32'h0BAD_F00D);
    chk("wfirst bvalid", 32'(wr_if.BVALID), 1);
    chk("wfirst awready held off", 32'(wr_if.AWREADY), 0);
    chk("wfirst wready held off", 32'(wr_if.WREADY), 0);
    wr_if.BREADY = 1'b1;
    tick();
    wr_if.BREADY = 1'b0;
    chk("wfirst done", 32'(wr_if.BVALID), 0);

    // Read error with RREADY low for five cycles
    rd_if.ARADDR  = 32'h0000_0020;
    rd_if.ARVALID = 1'b1;
    tick();
    rd_if.ARVALID = 1'b0;
    chk("bp request", 32'(read_request_o), 1);
    read_done_i  = 1'b1;
    read_error_i = 1'b1;
    read_data_i  = 32'h0000_1234;
    tick();
    read_done_i  = 1'b0;
    read_error_i = 1'b0;
    read_data_i  = 32'hFFFF_0000;
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("bp%0d rvalid", i), 32'(rd_if.RVALID), 1);
      chk($sformatf("bp%0d rdata", i), rd_if.RDATA, 32'h0000_1234);
      chk($sformatf("bp%0d rresp", i), 32'(rd_if.RRESP), 32'(SLVERR));
      chk($sformatf("bp%0d arready", i), 32'(rd_if.ARREADY), 0);
      tick();
    end
    rd_if.RREADY = 1'b1;
    tick();
    rd_if.RREADY = 1'b0;
    chk("bp rvalid clear", 32'(rd_if.RVALID), 0);
    chk("bp arready back", 32'(rd_if.ARREADY), 1);

`ifdef AXI_SLAVE_TIMEOUT_EN
    // No done: four WAIT cycles, then SLVERR; late done ignored
    wr_if.AWADDR  = 32'h0000_0044;
    wr_if.AWVALID = 1'b1;
    wr_if.WDATA   = 32'h5555_AAAA;
    wr_if.WSTRB   = 4'hF;
    wr_if.WVALID  = 1'b1;
    tick();
    wr_if.AWVALID = 1'b0;
    wr_if.WVALID  = 1'b0;
    chk("to request", 32'(write_request_o), 1);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk($sformatf("to wait%0d bvalid", i), 32'(wr_if.BVALID), 0);
    end
    tick();
    chk("to bvalid", 32'(wr_if.BVALID), 1);
    chk("to bresp", 32'(wr_if.BRESP), 32'(SLVERR));
    write_done_i = 1'b1;
    tick();
    write_done_i = 1'b0;
    chk("to late done bvalid", 32'(wr_if.BVALID), 1);
    chk("to late done bresp", 32'(wr_if.BRESP), 32'(SLVERR));
    wr_if.BREADY = 1'b1;
    tick();
    wr_if.BREADY = 1'b0;
    chk("to bvalid clear", 32'(wr_if.BVALID), 0);
`endif

    // Reset while both paths sit in WAIT
    wr_if.AWADDR  = 32'h0000_0030;
    wr_if.AWVALID = 1'b1;
    wr_if.WDATA   = 32'h7777_8888;
    wr_if.WSTRB   = 4'hF;
    wr_if.WVALID  = 1'b1;
    rd_if.ARADDR  = 32'h0000_0034;
    rd_if.ARVALID = 1'b1;
    tick();
    wr_if.AWVALID = 1'b0;
    wr_if.WVALID  = 1'b0;
    rd_if.ARVALID = 1'b0;
    tick();
    chk("mid wait request", 32'(write_request_o), 0);
    chk("mid wait bvalid", 32'(wr_if.BVALID), 0);
    rst = 1'b1;
    tick();
    chk("mid rst awready", 32'(wr_if.AWREADY), 0);
    chk("mid rst wready", 32'(wr_if.WREADY), 0);
    chk("mid rst arready", 32'(rd_if.ARREADY), 0);
    chk("mid rst bvalid", 32'(wr_if.BVALID), 0);
    chk("mid rst rvalid", 32'(rd_if.RVALID), 0);
    chk("mid rst wreq", 32'(write_request_o), 0);
    chk("mid rst rreq", 32'(read_request_o), 0);
    chk("mid rst wdata", write_data_o, 0);
    rst = 1'b0;
    tick();
    chk("mid release awready", 32'(wr_if.AWREADY), 1);
    chk("mid release wready", 32'(wr_if.WREADY), 1);
    chk("mid release arready", 32'(rd_if.ARREADY), 1);
    chk("mid release wreq", 32'(write_request_o), 0);

    run_write(wv[0], 10);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/axi_slave_port.md
# axi_slave_port

AXI-Lite slave endpoint sitting directly downstream of the bus master: consumes the master's write and read channels, decodes the address against one window, and presents a simple single-beat request/done port to a peripheral register file. Write and read paths are independent FSMs, one outstanding transaction each. Out-of-window accesses, and accesses flagged by the peripheral, complete with SLVERR.

## Interface
- ADDR_BASE, 32'h0000_0000, byte base address of the window
- ADDR_SIZE, 4096, window size in bytes; power of two, at least 4
- TIMEOUT_CYCLES, 256, WAIT-state limit; used only with the timeout feature
- axi_ACLK  in  1  clock; everything is on the rising edge
- axi_ARESET  in  1  reset; synchronous, active-high
- write_channel  axi_write_interface.slave  -  AW/W/B channels
- read_channel  axi_read_interface.slave  -  AR/R channels
- write_address_o  out  $clog2(ADDR_SIZE)  byte offset, equal to AWADDR minus ADDR_BASE
- write_data_o  out  32  captured WDATA
- write_strobe_o  out  4  captured WSTRB, forwarded unchanged even when 4'b0000
- write_request_o  out  1  one-cycle write pulse
- write_done_i  in  1  peripheral finished the write
- write_error_i  in  1  sampled together with write_done_i; 1 selects SLVERR
- read_address_o  out  $clog2(ADDR_SIZE)  byte offset
- read_request_o  out  1  one-cycle read pulse
- read_data_i  in  32  sampled together with read_done_i
- read_done_i  in  1  read data valid
- read_error_i  in  1  sampled together with read_done_i

## Operation
- Write FSM states: W_IDLE, W_REQUEST, W_WAIT, W_RESPONSE.
- W_IDLE:
  - AWREADY = !aw_held and WREADY = !w_held.
  - Address and data are captured independently, in the same cycle or in any order.
  - Once both are held, the FSM advances on the next edge.
- Address decode:
  - In range when ADDR_BASE <= AWADDR < ADDR_BASE + ADDR_SIZE.
  - In range: go to W_REQUEST.
  - Miss: go straight to W_RESPONSE with BRESP = SLVERR. No peripheral request is issued.
- W_REQUEST:
  - write_request_o = 1 for exactly one cycle.
  - If write_done_i is also high in this cycle, go to W_RESPONSE; otherwise go to W_WAIT.
- W_WAIT: on write_done_i, go to W_RESPONSE. BRESP = SLVERR if write_error_i, else OKAY.
- W_RESPONSE:
  - BVALID = 1, with BRESP held stable.
  - On BVALID & BREADY, clear the held flags and return to W_IDLE.
- Read FSM mirrors the write FSM with states R_IDLE, R_REQUEST, R_WAIT, R_RESPONSE.
  - ARREADY = 1 only in R_IDLE.
  - RDATA is captured on read_done_i.
  - On a decode miss, RDATA = 32'h0 and RRESP = SLVERR.
  - R_RESPONSE holds RVALID until RREADY.
- write_done_i and read_done_i are ignored outside their REQUEST and WAIT states.
- Write and read FSMs run concurrently. There is no ordering between the two paths.

## Timing
- Reset values:
  - AWREADY, WREADY, ARREADY, BVALID, RVALID, write_request_o and read_request_o are all 0 while axi_ARESET = 1.
  - BRESP = RRESP = OKAY and RDATA = 0.
  - Both FSMs are in IDLE with held flags cleared.
- The READY signals rise in the first cycle after reset deasserts.
- Best-case latency:
  - AW and W handshakes at cycle T.
  - write_request_o at T+1, with write_done_i at T+1.
  - BVALID at T+2.
  - The read path has the same latency.
- Decode miss: handshake at T, BVALID or RVALID at T+1.
- Reset asserted mid-transaction: both FSMs go to IDLE on the next edge. Pending responses are dropped and no request pulse is emitted.
- A new AW or W handshake is not accepted until the current B handshake completes. The master's early clear-to-send therefore back-pressures through READY.

## Configuration
- AXI_SLAVE_TIMEOUT_EN defined:
  - A counter clears on entry to W_WAIT or R_WAIT and increments every cycle in WAIT.
  - When it reaches TIMEOUT_CYCLES-1 without a done, the FSM goes to RESPONSE with SLVERR.
  - A late done is ignored.
- AXI_SLAVE_TIMEOUT_EN undefined: the WAIT states wait indefinitely, and TIMEOUT_CYCLES is unused.

## Structure
- Bus package:
  - axi_response_t, which already exists (OKAY, SLVERR).
  - New typedef axi_slave_state_t (IDLE, REQUEST, WAIT, RESPONSE), shared by both FSMs.
- One sub-module, axi_slave_timeout: counter with clear, enable and expired ports. It is instantiated once per path, only under AXI_SLAVE_TIMEOUT_EN.

## Test plan
- Write, same-cycle handshakes:
  - Stimulus: AW = ADDR_BASE+8 and W = 32'hDEADBEEF, strobe 4'hF, in the same cycle; peripheral done with no error in the request cycle.
  - Response: write_address_o = 8, write_data_o = 32'hDEADBEEF, write_strobe_o = 4'hF, write_request_o a single pulse, BVALID 2 cycles after the handshake with BRESP = OKAY.
- W before AW:
  - Stimulus: W arrives 3 cycles before AW.
  - Response: WREADY drops after the W capture, and exactly one write_request_o pulse follows the AW handshake.
- Decode miss:
  - Stimulus: read at ADDR_BASE + ADDR_SIZE.
  - Response: no read_request_o, RVALID the next cycle with RRESP = SLVERR and RDATA = 0.
- Response back-pressure:
  - Stimulus: peripheral read error with read_data_i = 32'h1234; RREADY held low for 5 cycles.
  - Response: RVALID, RDATA and RRESP = SLVERR remain stable until RREADY rises; ARREADY stays 0 throughout.
- Timeout, with AXI_SLAVE_TIMEOUT_EN and TIMEOUT_CYCLES = 4:
  - Stimulus: write with no write_done_i.
  - Response: BVALID with SLVERR after the 4 WAIT cycles; a later write_done_i pulse has no effect.
- Reset mid-operation:
  - Stimulus: axi_ARESET asserted while in W_WAIT.
  - Response: all outputs at their reset values the next cycle; AWREADY = WREADY = 1 one cycle after release.
